// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, default halt encoding and fetch FSM states
package fetch_pkg;

    localparam int IMEM_AW = 7;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry {pc, instruction} FIFO; slot 0 is always the head
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [IMEM_AW-1:0] push_pc,
    input  logic [INSTR_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic               full,
    output logic               empty,
    output logic [IMEM_AW-1:0] head_pc,
    output logic [INSTR_W-1:0] head_data
);

    logic [1:0]         count_q, count_d;
    logic [IMEM_AW-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [INSTR_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic               pop_ok, push_ok;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_d     = count_q;
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        tail_pc_d   = tail_pc_q;
        tail_data_d = tail_data_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            // Pop shifts the tail forward; a same-cycle push lands behind whatever remains.
            if (pop_ok) begin
                head_pc_d   = tail_pc_q;
                head_data_d = tail_data_q;
            end
            if (push_ok) begin
                if ((count_q == 2'd0) || (pop_ok && count_q == 2'd1)) begin
                    head_pc_d   = push_pc;
                    head_data_d = push_data;
                end else begin
                    tail_pc_d   = push_pc;
                    tail_data_d = push_data;
                end
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            head_pc_q   <= '0;
            head_data_q <= '0;
            tail_pc_q   <= '0;
            tail_data_q <= '0;
        end else begin
            count_q     <= count_d;
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
            tail_pc_q   <= tail_pc_d;
            tail_data_q <= tail_data_d;
        end
    end

    assign head_pc   = head_pc_q;
    assign head_data = head_data_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - pc, run/halt FSM and redirect control around the fetch buffer
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [IMEM_AW-1:0] RESET_PC  = 7'd0,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_address,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               redirect_valid,
    input  logic [IMEM_AW-1:0] redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_out,
    output logic [IMEM_AW-1:0] inst_pc,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic               buf_full, buf_empty;
    logic               transfer, push, pop;

    assign inst_valid = !buf_empty;
    assign transfer   = inst_valid && inst_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (redirect_valid) begin
            // Redirect wins over everything: the memory word and any transfer this cycle are dropped.
            state_d = ST_RUN;
            pc_d    = redirect_pc;
        end else begin
            pop = transfer;
            if (state_q == ST_RUN && (!buf_full || transfer)) begin
                push = 1'b1;
                pc_d = pc_q + 7'd1;
                if (imem_instruction == HALT_WORD) begin
                    state_d = ST_HALTED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_pc   (pc_q),
        .push_data (imem_instruction),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (buf_full),
        .empty     (buf_empty),
        .head_pc   (inst_pc),
        .head_data (inst_out)
    );

    assign imem_address = pc_q;
    assign imem_rd      = 1'b1;
    assign halted       = (state_q == ST_HALTED);

endmodule
